// File: rtl/flash_uart_tx.sv
// flash_uart_tx
//   Buffers bytes from the SPI-flash read stream in a circular FIFO and
//   sends each one as an 8N1 UART frame. Queued bytes go out back to back
//   with no idle gap. Bytes written while the FIFO is full are dropped, and
//   the drop is latched in 'overflow'.
// Ports
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   pi_data    : byte to send, qualified by pi_flag
//   pi_flag    : one-cycle write strobe (one byte per high cycle)
//   tx         : UART line, idle high, registered
//   fifo_full  : registered, stored count == FIFO_DEPTH
//   overflow   : sticky drop indicator, cleared only by reset
//   busy       : frame on the line or FIFO non-empty
module flash_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BAUD_W       = $clog2(BAUD_CNT_MAX);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, cnt_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;

  logic baud_last, frame_end, wr_en, pop, fsm_idle_nxt, busy_nxt;

  always_comb begin
    baud_last = (baud_cnt == BAUD_LAST);
    frame_end = (state == STOP) && baud_last;
    // Full is judged from the registered flag, so a same-edge pop never
    // rescues a byte arriving into a full FIFO.
    wr_en     = pi_flag && !fifo_full;
    // Pop uses the registered count: a byte written into an empty FIFO is
    // only visible to the transmitter on the following edge.
    pop       = (count != '0) && ((state == IDLE) || frame_end);
    cnt_nxt   = count;
    case ({wr_en, pop})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
    fsm_idle_nxt = ((state == IDLE) || frame_end) && !pop;
    busy_nxt     = (cnt_nxt != '0) || !fsm_idle_nxt;
  end

  // Storage carries no reset: an empty FIFO after reset is defined by the
  // pointers and count alone.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= pi_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shreg  <= mem[rd_ptr];
      end
      if (pi_flag && fifo_full) overflow <= 1'b1;
      count     <= cnt_nxt;
      fifo_full <= (cnt_nxt == CNT_FULL);
      busy      <= busy_nxt;

      // Every state leaves on baud_last, where the counter wraps to 0, so
      // the wrap doubles as the clear on state entry.
      baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        DATA: begin
          if (baud_last) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (baud_last) begin
            // Chain straight into the next start bit when data is waiting.
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
